// File: rtl/keylock_pkg.sv
// Shared keypad / lock definitions: default key geometry and the buffer
// occupancy states that the lock FSM also decodes.
package keylock_pkg;

   localparam int DEF_KEY_W = 8;
   localparam int DEF_DEPTH = 4;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      PARTIAL = 2'd1,
      FULL    = 2'd2
   } occ_state_t;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: remembers last cycle's level in a register and flags
// the first cycle the level is seen high, so a held input yields one event.
module rise_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic level,
   output logic pulse
);

   logic hist_r;

   // History register, updated every cycle regardless of any enable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_r <= 1'b0;
      end else begin
         hist_r <= level;
      end
   end

   assign pulse = level & ~hist_r;

endmodule

// File: rtl/key_entry_buffer.sv
// Keypad entry buffer: shifts one key code per press into a DEPTH-slot
// buffer (slot 0 newest), with backspace, clear, overflow policy and an
// optional idle auto-clear. Event effects land on the edge after detection.
module key_entry_buffer
   import keylock_pkg::*;
#(
   parameter int KEY_W       = DEF_KEY_W,
   parameter int DEPTH       = DEF_DEPTH,
   parameter int WRAP        = 1,
   parameter int IDLE_CYCLES = 0,
   parameter int CNT_W       = $clog2(DEPTH + 1)
) (
   input  logic                   hwclk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic [KEY_W-1:0]       key,
   input  logic                   button_pressed,
   input  logic                   backspace,
   input  logic                   clear,
   output logic [DEPTH*KEY_W-1:0] typed,
   output logic [CNT_W-1:0]       count,
   output logic                   full,
   output logic                   new_key,
   output logic                   reject,
   output logic                   timeout
);

   localparam int               BUF_W    = DEPTH * KEY_W;
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);

   logic             press_ev_s;
   logic             bksp_ev_s;
   logic             idle_fire_s;
   logic [BUF_W-1:0] typed_r;
   logic [BUF_W-1:0] typed_nxt_s;
   logic [BUF_W-1:0] shift_in_s;
   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] count_nxt_s;
   logic             new_key_r;
   logic             new_key_nxt_s;
   logic             reject_r;
   logic             reject_nxt_s;
   logic             timeout_r;
   logic             timeout_nxt_s;
   logic             full_r;
   occ_state_t       state_r;
   occ_state_t       state_nxt_s;

   rise_detect u_press_edge (
      .clk   (hwclk),
      .rst_n (rst_n),
      .level (button_pressed),
      .pulse (press_ev_s)
   );

   rise_detect u_bksp_edge (
      .clk   (hwclk),
      .rst_n (rst_n),
      .level (backspace),
      .pulse (bksp_ev_s)
   );

   // Buffer image with the new key in slot 0 and every older slot moved up one
   always_comb begin
      shift_in_s = typed_r << KEY_W;
      shift_in_s[KEY_W-1:0] = key;
   end

   // Resolve this cycle's events by priority: clear, backspace, press, idle timeout
   always_comb begin
      typed_nxt_s   = typed_r;
      count_nxt_s   = count_r;
      new_key_nxt_s = 1'b0;
      reject_nxt_s  = 1'b0;
      timeout_nxt_s = 1'b0;
      if (clear) begin
         typed_nxt_s = {BUF_W{1'b0}};
         count_nxt_s = CNT_ZERO;
      end else if (enable && bksp_ev_s) begin
         // A backspace on an empty buffer still swallows a coincident press
         if (count_r != CNT_ZERO) begin
            typed_nxt_s = typed_r >> KEY_W;
            count_nxt_s = count_r - CNT_ONE;
         end else begin
            typed_nxt_s = typed_r;
         end
      end else if (enable && press_ev_s) begin
         if (count_r < CNT_MAX) begin
            typed_nxt_s   = shift_in_s;
            count_nxt_s   = count_r + CNT_ONE;
            new_key_nxt_s = 1'b1;
         end else if (WRAP != 0) begin
            typed_nxt_s   = shift_in_s;
            new_key_nxt_s = 1'b1;
         end else begin
            reject_nxt_s = 1'b1;
         end
      end else if (idle_fire_s) begin
         typed_nxt_s   = {BUF_W{1'b0}};
         count_nxt_s   = CNT_ZERO;
         timeout_nxt_s = 1'b1;
      end else begin
         typed_nxt_s = typed_r;
      end
   end

   // Occupancy state follows the count the buffer is about to hold
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         EMPTY: begin
            if (count_nxt_s == CNT_ZERO) state_nxt_s = EMPTY;
            else if (count_nxt_s == CNT_MAX) state_nxt_s = FULL;
            else state_nxt_s = PARTIAL;
         end
         PARTIAL: begin
            if (count_nxt_s == CNT_ZERO) state_nxt_s = EMPTY;
            else if (count_nxt_s == CNT_MAX) state_nxt_s = FULL;
            else state_nxt_s = PARTIAL;
         end
         FULL: begin
            if (count_nxt_s == CNT_ZERO) state_nxt_s = EMPTY;
            else if (count_nxt_s != CNT_MAX) state_nxt_s = PARTIAL;
            else state_nxt_s = FULL;
         end
         default: state_nxt_s = EMPTY;
      endcase
   end

   // Buffer contents, count and single-cycle status pulses
   always_ff @(posedge hwclk or negedge rst_n) begin
      if (!rst_n) begin
         typed_r   <= {BUF_W{1'b0}};
         count_r   <= CNT_ZERO;
         new_key_r <= 1'b0;
         reject_r  <= 1'b0;
         timeout_r <= 1'b0;
      end else begin
         typed_r   <= typed_nxt_s;
         count_r   <= count_nxt_s;
         new_key_r <= new_key_nxt_s;
         reject_r  <= reject_nxt_s;
         timeout_r <= timeout_nxt_s;
      end
   end

   // Occupancy state register; full is registered from the same next state
   always_ff @(posedge hwclk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= EMPTY;
         full_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         full_r  <= (state_nxt_s == FULL);
      end
   end

   generate
      if (IDLE_CYCLES > 0) begin : g_idle
         localparam int                IDLE_W    = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
         localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);

         logic [IDLE_W-1:0] idle_r;
         logic              activity_s;

         // Any enabled press/backspace (even a rejected press) counts as user activity
         assign activity_s  = clear | (enable & (press_ev_s | bksp_ev_s));
         assign idle_fire_s = enable && (idle_r == IDLE_LAST) && (count_r != CNT_ZERO);

         // Idle counter: restarts on activity or empty buffer, holds while disabled
         always_ff @(posedge hwclk or negedge rst_n) begin
            if (!rst_n) begin
               idle_r <= {IDLE_W{1'b0}};
            end else if (activity_s || idle_fire_s || (count_r == CNT_ZERO)) begin
               idle_r <= {IDLE_W{1'b0}};
            end else if (enable) begin
               idle_r <= idle_r + IDLE_W'(1);
            end else begin
               idle_r <= idle_r;
            end
         end
      end else begin : g_no_idle
         assign idle_fire_s = 1'b0;
      end
   endgenerate

   assign typed   = typed_r;
   assign count   = count_r;
   assign full    = full_r;
   assign new_key = new_key_r;
   assign reject  = reject_r;
   assign timeout = timeout_r;

endmodule

// File: doc/key_entry_buffer.md
Name: key_entry_buffer

Overview:
- Parametrised keypad entry buffer; successor to keyList.
- Captures one key code per debounced button press into a DEPTH-slot shift buffer. Newest code sits in the least-significant slot.
- Adds over keyList: backspace, clear, entry count, full flag, overflow policy (wrap or reject), idle timeout auto-clear.
- Sits between the keypad decoder and the code comparator / lock FSM.

Parameters:
KEY_W, 8, width of one key code in bits
DEPTH, 4, number of key slots held
WRAP, 1, 1 = press when full discards oldest slot; 0 = press when full is rejected
IDLE_CYCLES, 0, hwclk cycles of inactivity before auto-clear; 0 disables timeout
CNT_W, $clog2(DEPTH+1), width of count output (derived; do not override)

Ports:
hwclk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  event processing enable
key  in  KEY_W  key code, sampled on the press-edge cycle
button_pressed  in  1  level, high while a key is held
backspace  in  1  level, high while backspace is held
clear  in  1  level, synchronous clear request
typed  out  DEPTH*KEY_W  buffer; slot 0 = bits [KEY_W-1:0] = newest
count  out  CNT_W  number of valid slots, 0..DEPTH
full  out  1  count == DEPTH
new_key  out  1  one-cycle pulse, a key was accepted
reject  out  1  one-cycle pulse, press dropped (WRAP=0 and full)
timeout  out  1  one-cycle pulse, idle auto-clear fired

Behaviour:
- Reset: rst_n is asynchronous and active-low. While low, typed, count, full, new_key, reject, timeout, the idle counter and the edge-detect history registers are all 0.
- Edge detection:
  - Press event = button_pressed high now and low on the previous cycle.
  - Backspace event = same rule on backspace.
  - History registers update every cycle regardless of enable. A key held for N cycles yields exactly one event.
- Event effects apply at the clock edge after the event cycle, so outputs reflect the event 1 cycle after detection.
- Priority within one cycle: clear > backspace event > press event. The lower-priority events are dropped, not queued.
- enable = 0: clear is still honoured. Backspace and press events are discarded. The idle counter holds.
- Clear (level, enable-independent): typed = 0, count = 0, idle counter = 0. No pulse.
- Press, count < DEPTH: typed = {typed[(DEPTH-1)*KEY_W-1:0], key}, count+1, new_key = 1.
- Press, count == DEPTH:
  - WRAP=1: shift in, oldest slot lost, count stays DEPTH, new_key = 1.
  - WRAP=0: buffer unchanged, reject = 1.
- Backspace, count > 0: typed = typed >> KEY_W (top slot zero-filled), count-1. No pulse.
- Backspace, count == 0: no-op.
- Unused slots (index >= count) always read 0.
- full is registered and equal to (count == DEPTH) on every cycle.
- Idle counter:
  - Reset to 0 on any accepted event (press, backspace, clear) or whenever count == 0.
  - Otherwise increments while enable = 1.
  - When it reaches IDLE_CYCLES-1 with count > 0: next cycle typed = 0, count = 0, timeout = 1.
  - A press event in the firing cycle wins: the counter resets and no timeout occurs.
  - IDLE_CYCLES = 0: counter logic removed, timeout tied 0.
- Occupancy FSM, derived from count: EMPTY (count 0), PARTIAL, FULL.
  - EMPTY -> PARTIAL on press.
  - PARTIAL -> FULL on press at count DEPTH-1.
  - FULL -> PARTIAL on backspace.
  - Any state -> EMPTY on clear or timeout.
  - When DEPTH = 1: EMPTY <-> FULL directly.
- Pulses are single-cycle and registered.

Decomposition:
- keylock_pkg: default KEY_W / DEPTH constants, and the occupancy state enum (EMPTY, PARTIAL, FULL) shared with the lock FSM.
- Sub-module rise_detect: 1-bit registered rising-edge pulse, async active-low reset. Instantiated for button_pressed and backspace.

Test Plan:
- Reset and hold: rst_n low mid-entry with count = 2 -> all outputs 0 immediately (asynchronously); after release, button held 6 cycles with key = 0x03 -> exactly one new_key, typed = 0x00000003, count = 1.
- Wrap overflow (KEY_W=8, DEPTH=4, WRAP=1): press keys 1..8 -> typed = 0x05060708, count = 4, full = 1, 8 new_key pulses.
- Reject overflow (WRAP=0): press keys 1..8 -> typed = 0x01020304, 4 new_key pulses and 4 reject pulses.
- Backspace: from typed = 0x01020304, 2 backspace events -> typed = 0x00000102, count = 2, full = 0. Then 3 more backspace events -> count = 0, no underflow.
- Priority: press event (key 0x09) coincident with clear -> typed = 0, count = 0, no new_key. Press coincident with backspace at count 3 -> count = 2, key not inserted.
- Timeout (IDLE_CYCLES=16): one press, then idle -> timeout pulse 16 cycles after the press is applied, count = 0. Repeat with enable = 0 for 40 cycles -> no timeout, buffer retained.
